// File: rtl/hazard_stall_controller.sv
// Pipeline sequencer around the decoder: load-use stall, data-memory wait with timeout, redirect flush.
// Optional build macro HAZARD_PERF_CNT_EN adds stall/flush cycle counters (stall_cnt_o, flush_cnt_o).
module hazard_stall_controller #(
  parameter int MEM_TIMEOUT  = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       dec_valid_i,
  input  logic [4:0] dec_rs1_i,
  input  logic [4:0] dec_rs2_i,
  input  logic [4:0] dec_rd_i,
  input  logic       dec_uses_rs2_i,
  input  logic       dec_is_load_i,
  input  logic       dec_mem_op_i,
  input  logic       redirect_i,
  input  logic       dmem_ack_i,
  output logic       stall_o,
  output logic       pc_en_o,
  output logic       flush_o,
  output logic       dmem_req_o,
  output logic       mem_err_o,
  output logic [1:0] state_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  // Handshake: dmem_req_o is a level held from the first MEM_WAIT cycle until the
  // cycle dmem_ack_i is seen high (or the timeout fires); ack outside MEM_WAIT is ignored.

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_LOAD_USE = 2'b01,
    ST_MEM_WAIT = 2'b10,
    ST_FLUSH    = 2'b11
  } state_t;

  localparam logic [7:0] TMO_LAST   = 8'(MEM_TIMEOUT - 1);
  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic [1:0]  flush_cnt_q, flush_cnt_d;
  logic        ex_valid_q, ex_valid_d;
  logic [4:0]  ex_rd_q, ex_rd_d;
  logic        ex_is_load_q, ex_is_load_d;
  logic        stall_q, stall_d;
  logic        flush_q, flush_d;
  logic        dmem_req_q, dmem_req_d;
  logic        mem_err_q, mem_err_d;

  logic        advance;
  logic        hazard;

  always_comb begin
    advance = dec_valid_i && !stall_q && !flush_q;
    hazard  = ex_valid_q && ex_is_load_q && (ex_rd_q != 5'd0) && dec_valid_i &&
              ((dec_rs1_i == ex_rd_q) || (dec_uses_rs2_i && (dec_rs2_i == ex_rd_q)));
  end

  always_comb begin
    state_d     = state_q;
    tmo_cnt_d   = tmo_cnt_q;
    flush_cnt_d = flush_cnt_q;
    mem_err_d   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (redirect_i) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = FLUSH_LOAD;
        end else if (hazard) begin
          state_d = ST_LOAD_USE;
        end else if (advance && dec_mem_op_i) begin
          state_d   = ST_MEM_WAIT;
          tmo_cnt_d = 8'd0;
        end
      end
      ST_LOAD_USE: begin
        // The bubble is a single cycle; a redirect makes it moot.
        if (redirect_i) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = FLUSH_LOAD;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ack_i) begin
          state_d = ST_RUN;
        end else if (tmo_cnt_q >= TMO_LAST) begin
          state_d   = ST_RUN;
          mem_err_d = 1'b1;
        end else if (tmo_cnt_q != 8'hFF) begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      ST_FLUSH: begin
        if (redirect_i) begin
          flush_cnt_d = FLUSH_LOAD;
        end else if (flush_cnt_q == 2'd0) begin
          state_d = ST_RUN;
        end else begin
          flush_cnt_d = flush_cnt_q - 2'd1;
        end
      end
      default: state_d = ST_RUN;
    endcase

    // Outputs are registered decodes of the next state.
    stall_d    = (state_d == ST_LOAD_USE) || (state_d == ST_MEM_WAIT);
    flush_d    = (state_d == ST_FLUSH);
    dmem_req_d = (state_d == ST_MEM_WAIT);
  end

  always_comb begin
    ex_valid_d   = advance;
    ex_rd_d      = advance ? dec_rd_i : ex_rd_q;
    ex_is_load_d = advance ? dec_is_load_i : ex_is_load_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_RUN;
      tmo_cnt_q    <= 8'd0;
      flush_cnt_q  <= 2'd0;
      ex_valid_q   <= 1'b0;
      ex_rd_q      <= 5'd0;
      ex_is_load_q <= 1'b0;
      stall_q      <= 1'b0;
      flush_q      <= 1'b0;
      dmem_req_q   <= 1'b0;
      mem_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmo_cnt_q    <= tmo_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      ex_valid_q   <= ex_valid_d;
      ex_rd_q      <= ex_rd_d;
      ex_is_load_q <= ex_is_load_d;
      stall_q      <= stall_d;
      flush_q      <= flush_d;
      dmem_req_q   <= dmem_req_d;
      mem_err_q    <= mem_err_d;
    end
  end

  assign stall_o    = stall_q;
  assign pc_en_o    = !stall_q;
  assign flush_o    = flush_q;
  assign dmem_req_o = dmem_req_q;
  assign mem_err_o  = mem_err_q;
  assign state_o    = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_pc_q, stall_pc_d;
  logic [31:0] flush_pc_q, flush_pc_d;

  always_comb begin
    stall_pc_d = stall_q ? stall_pc_q + 32'd1 : stall_pc_q;
    flush_pc_d = flush_q ? flush_pc_q + 32'd1 : flush_pc_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_pc_q <= 32'd0;
      flush_pc_q <= 32'd0;
    end else begin
      stall_pc_q <= stall_pc_d;
      flush_pc_q <= flush_pc_d;
    end
  end

  assign stall_cnt_o = stall_pc_q;
  assign flush_cnt_o = flush_pc_q;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_hazard_stall_controller;

  localparam int MT = 16;
  localparam int FC = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       dec_valid, dec_uses_rs2, dec_is_load, dec_mem_op, redirect, ack;
  logic [4:0] dec_rs1, dec_rs2, dec_rd;
  logic       stall_o, pc_en_o, flush_o, dmem_req_o, mem_err_o;
  logic [1:0] state_o;

  hazard_stall_controller #(.MEM_TIMEOUT(MT), .FLUSH_CYCLES(FC)) dut (
    .clk_i(clk), .rst_i(rst),
    .dec_valid_i(dec_valid), .dec_rs1_i(dec_rs1), .dec_rs2_i(dec_rs2), .dec_rd_i(dec_rd),
    .dec_uses_rs2_i(dec_uses_rs2), .dec_is_load_i(dec_is_load), .dec_mem_op_i(dec_mem_op),
    .redirect_i(redirect), .dmem_ack_i(ack),
    .stall_o(stall_o), .pc_en_o(pc_en_o), .flush_o(flush_o), .dmem_req_o(dmem_req_o),
    .mem_err_o(mem_err_o), .state_o(state_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model: remaining flush cycles, age of the pending memory access, bubble flag
  int         m_mem_age;
  int         m_flush_left;
  bit         m_lu;
  bit         m_err;
  bit         m_ex_v;
  bit         m_ex_ld;
  logic [4:0] m_ex_rd;

  task automatic model_reset();
    m_mem_age = -1; m_flush_left = 0; m_lu = 0; m_err = 0;
    m_ex_v = 0; m_ex_ld = 0; m_ex_rd = 5'd0;
  endtask

  function automatic bit exp_stall();
    return m_lu || (m_mem_age >= 0);
  endfunction

  function automatic logic [1:0] exp_state();
    if (m_mem_age >= 0) return 2'd2;
    if (m_lu) return 2'd1;
    if (m_flush_left > 0) return 2'd3;
    return 2'd0;
  endfunction

  task automatic model_update();
    bit busy;
    bit adv;
    bit haz;
    busy = exp_stall() || (m_flush_left > 0);
    adv  = dec_valid && !busy;
    haz  = m_ex_v && m_ex_ld && (m_ex_rd != 5'd0) && dec_valid &&
           ((dec_rs1 == m_ex_rd) || (dec_uses_rs2 && dec_rs2 == m_ex_rd));
    m_err = 0;
    if (m_mem_age >= 0) begin
      if (ack) m_mem_age = -1;
      else if (m_mem_age + 1 == MT) begin m_mem_age = -1; m_err = 1; end
      else m_mem_age++;
    end else if (m_flush_left > 0) begin
      if (redirect) m_flush_left = FC + 1;
      m_flush_left--;
    end else if (m_lu) begin
      m_lu = 0;
      if (redirect) m_flush_left = FC;
    end else begin
      if (redirect) m_flush_left = FC;
      else if (haz) m_lu = 1;
      else if (dec_valid && dec_mem_op) m_mem_age = 0;
    end
    if (adv) begin m_ex_v = 1; m_ex_rd = dec_rd; m_ex_ld = dec_is_load; end
    else m_ex_v = 0;
  endtask

  // scoreboard
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("stall",    32'(stall_o),    32'(exp_stall()));
    chk("pc_en",    32'(pc_en_o),    32'(!exp_stall()));
    chk("flush",    32'(flush_o),    32'(m_flush_left > 0));
    chk("dmem_req", 32'(dmem_req_o), 32'(m_mem_age >= 0));
    chk("mem_err",  32'(mem_err_o),  32'(m_err));
    chk("state",    32'(state_o),    32'(exp_state()));
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    if (!rst) model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_dec(input bit v, input int rs1, input int rs2, input int rd,
                         input bit u2, input bit ld, input bit mem);
    dec_valid = v; dec_rs1 = 5'(rs1); dec_rs2 = 5'(rs2); dec_rd = 5'(rd);
    dec_uses_rs2 = u2; dec_is_load = ld; dec_mem_op = mem;
  endtask

  task automatic idle();
    set_dec(0, 0, 0, 0, 0, 0, 0);
    redirect = 0; ack = 0;
  endtask

  task automatic rand_inputs();
    dec_valid    = ($urandom_range(0, 9) < 8);
    dec_rs1      = 5'($urandom_range(0, 3));
    dec_rs2      = 5'($urandom_range(0, 3));
    dec_rd       = 5'($urandom_range(0, 3));
    dec_uses_rs2 = 1'($urandom_range(0, 1));
    dec_is_load  = ($urandom_range(0, 2) == 0);
    dec_mem_op   = dec_is_load ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 5) == 0);
    redirect     = ($urandom_range(0, 15) == 0);
    ack          = ($urandom_range(0, 7) == 0);
  endtask

  task automatic load_use_pair();
    set_dec(1, 0, 0, 5, 0, 1, 0);
    tick();
    set_dec(1, 5, 1, 6, 1, 0, 0);
    tick();
    chk("lu_state", 32'(state_o), 32'd1);
    chk("lu_stall", 32'(stall_o), 32'd1);
    chk("lu_pc_en", 32'(pc_en_o), 32'd0);
    tick();
    chk("lu_back_state", 32'(state_o), 32'd0);
    chk("lu_back_stall", 32'(stall_o), 32'd0);
    tick();
    chk("lu_add_adv", 32'(stall_o), 32'd0);
    idle();
    tick();
  endtask

  initial begin
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_pc_en", 32'(pc_en_o), 32'd1);
    chk("rst_flush", 32'(flush_o), 32'd0);
    chk("rst_req",   32'(dmem_req_o), 32'd0);
    chk("rst_err",   32'(mem_err_o), 32'd0);
    chk("rst_state", 32'(state_o), 32'd0);
    rst = 0;
    tick();

    load_use_pair();

    // load to x0 never creates a hazard
    set_dec(1, 0, 0, 0, 0, 1, 0);
    tick();
    set_dec(1, 0, 1, 6, 1, 0, 0);
    tick();
    chk("x0_stall", 32'(stall_o), 32'd0);
    chk("x0_state", 32'(state_o), 32'd0);
    idle();
    tick();

    // store acked in the third wait cycle
    set_dec(1, 2, 3, 0, 1, 0, 1);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      chk("st_req", 32'(dmem_req_o), 32'd1);
      chk("st_stall", 32'(stall_o), 32'd1);
      if (i == 2) ack = 1;
      tick();
    end
    ack = 0;
    chk("st_req_drop", 32'(dmem_req_o), 32'd0);
    chk("st_stall_drop", 32'(stall_o), 32'd0);
    chk("st_no_err", 32'(mem_err_o), 32'd0);

    // load with no ack runs into the timeout
    set_dec(1, 1, 0, 7, 0, 1, 1);
    tick();
    idle();
    for (int i = 0; i < MT; i++) begin
      chk("tmo_req", 32'(dmem_req_o), 32'd1);
      chk("tmo_err_low", 32'(mem_err_o), 32'd0);
      tick();
    end
    chk("tmo_err", 32'(mem_err_o), 32'd1);
    chk("tmo_req_drop", 32'(dmem_req_o), 32'd0);
    chk("tmo_state", 32'(state_o), 32'd0);
    tick();
    chk("tmo_err_pulse", 32'(mem_err_o), 32'd0);

    // single redirect, then a redirect repeated in the first flush cycle
    redirect = 1;
    tick();
    redirect = 0;
    chk("fl_flush1", 32'(flush_o), 32'd1);
    chk("fl_stall", 32'(stall_o), 32'd0);
    chk("fl_state", 32'(state_o), 32'd3);
    tick();
    chk("fl_flush2", 32'(flush_o), 32'd1);
    tick();
    chk("fl_done", 32'(flush_o), 32'd0);
    redirect = 1;
    tick();
    chk("fx_flush1", 32'(flush_o), 32'd1);
    tick();
    redirect = 0;
    chk("fx_flush2", 32'(flush_o), 32'd1);
    tick();
    chk("fx_flush3", 32'(flush_o), 32'd1);
    tick();
    chk("fx_done", 32'(flush_o), 32'd0);

    // asynchronous reset in the middle of a memory wait
    set_dec(1, 2, 3, 0, 1, 0, 1);
    tick();
    idle();
    tick();
    chk("ar_pre_req", 32'(dmem_req_o), 32'd1);
    #2 rst = 1;
    model_reset();
    #1;
    chk("ar_req", 32'(dmem_req_o), 32'd0);
    chk("ar_stall", 32'(stall_o), 32'd0);
    chk("ar_state", 32'(state_o), 32'd0);
    @(negedge clk);
    rst = 0;
    tick();
    load_use_pair();

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
